hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_match.sv | 36 +++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the MIPS stall/forward controller.
//   - default field widths (Tuse/Tnew, register index, forwarding select)
//   - pipeline stage indices as seen from D (1 = E, 2 = M, 3 = W)
//   - default mult/div busy lengths
//   - sb_entry_t: one in-flight writer {destination, remaining Tnew}
package hazard_pkg;

    localparam int unsigned TNEW_W_DEF = 3;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned SEL_W_DEF  = 3;

    localparam int unsigned STG_E = 1;
    localparam int unsigned STG_M = 2;
    localparam int unsigned STG_W = 3;

    // Busy cycles; the busy counter is 4 bits wide so both must stay <= 15.
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    typedef struct packed {
        logic [REG_W_DEF-1:0]  dst;
        logic [TNEW_W_DEF-1:0] tnew;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard check against the writer scoreboard.
// Ports:
//   sb_dst, sb_tnew  in   scoreboard, index 0 = stage E (entry[1])
//   rd               in   source register read by the D-stage instruction
//   need             in   operand is actually read
//   tuse             in   cycles until the operand is consumed
//   stall_r          out  youngest matching writer is not ready in time
//   fwd_sel          out  stage number to forward from, 0 = register file
module hazard_match #(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned TNEW_W = 3,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned SEL_W  = 3
) (
    input  logic [NSTAGE-1:0][REG_W-1:0]  sb_dst,
    input  logic [NSTAGE-1:0][TNEW_W-1:0] sb_tnew,
    input  logic [REG_W-1:0]              rd,
    input  logic                          need,
    input  logic [TNEW_W-1:0]             tuse,
    output logic                          stall_r,
    output logic [SEL_W-1:0]              fwd_sel
);

    // Walk from oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        stall_r = 1'b0;
        fwd_sel = '0;
        for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
            if (need && (rd != '0) && (sb_dst[k] == rd)) begin
                stall_r = (sb_tnew[k] > tuse);
                fwd_sel = (sb_tnew[k] == '0) ? SEL_W'(k + 1) : '0;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the D stage of the MIPS pipeline.
// Keeps a shift register of in-flight writers for NSTAGE stages after D and a
// mult/div busy counter; produces the D-stage stall and per-operand forwarding
// selects combinationally from the D inputs and that registered state.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   d_valid                         D holds a real instruction
//   d_rs/d_rt, d_need_*, d_tuse_*   source operands and their Tuse
//   d_dst, d_tnew                   destination (0 = none) and Tnew in E
//   d_md_use, d_md_start, d_md_div  HI/LO use, mult/div start, start is div
//   stall                           freeze F/D, bubble into E
//   fwd_rs_sel, fwd_rt_sel          0 = register file, k = stage k
//   md_busy, md_count               mult/div unit busy and remaining cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned TNEW_W   = TNEW_W_DEF,
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic              d_need_rs,
    input  logic              d_need_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_W-1:0]  d_dst,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic              d_md_start,
    input  logic              d_md_div,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy,
    output logic [3:0]        md_count
);

    // Index 0 is the instruction now in E, NSTAGE-1 the oldest tracked one.
    logic [NSTAGE-1:0][REG_W-1:0]  sb_dst_q,  sb_dst_d;
    logic [NSTAGE-1:0][TNEW_W-1:0] sb_tnew_q, sb_tnew_d;
    logic [3:0]                    md_count_q, md_count_d;

    logic stall_rs, stall_rt, stall_md;

    hazard_match #(
        .NSTAGE (NSTAGE),
        .TNEW_W (TNEW_W),
        .REG_W  (REG_W),
        .SEL_W  (SEL_W)
    ) u_match_rs (
        .sb_dst  (sb_dst_q),
        .sb_tnew (sb_tnew_q),
        .rd      (d_rs),
        .need    (d_need_rs),
        .tuse    (d_tuse_rs),
        .stall_r (stall_rs),
        .fwd_sel (fwd_rs_sel)
    );

    hazard_match #(
        .NSTAGE (NSTAGE),
        .TNEW_W (TNEW_W),
        .REG_W  (REG_W),
        .SEL_W  (SEL_W)
    ) u_match_rt (
        .sb_dst  (sb_dst_q),
        .sb_tnew (sb_tnew_q),
        .rd      (d_rt),
        .need    (d_need_rt),
        .tuse    (d_tuse_rt),
        .stall_r (stall_rt),
        .fwd_sel (fwd_rt_sel)
    );

    assign md_busy  = (md_count_q != 4'd0);
    assign md_count = md_count_q;
    assign stall_md = d_md_use && md_busy;
    assign stall    = d_valid && (stall_rs || stall_rt || stall_md);

    // Scoreboard shift: a stalled or empty D slot enters E as a bubble.
    always_comb begin
        sb_dst_d  = sb_dst_q;
        sb_tnew_d = sb_tnew_q;
        if (stall || !d_valid) begin
            sb_dst_d[0]  = '0;
            sb_tnew_d[0] = '0;
        end else begin
            sb_dst_d[0]  = d_dst;
            sb_tnew_d[0] = d_tnew;
        end
        for (int k = 1; k < int'(NSTAGE); k++) begin
            sb_dst_d[k]  = sb_dst_q[k-1];
            sb_tnew_d[k] = (sb_tnew_q[k-1] == '0) ? '0 : sb_tnew_q[k-1] - 1'b1;
        end
    end

    // A start only loads once it actually issues, so it never stalls on itself.
    always_comb begin
        md_count_d = md_count_q;
        if (d_valid && d_md_start && !stall) begin
            md_count_d = d_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (md_count_q != 4'd0) begin
            md_count_d = md_count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_dst_q   <= '0;
            sb_tnew_q  <= '0;
            md_count_q <= 4'd0;
        end else begin
            sb_dst_q   <= sb_dst_d;
            sb_tnew_q  <= sb_tnew_d;
            md_count_q <= md_count_d;
        end
    end

endmodule
